tex_fetch: RTL and testbench

TEX_FETCH -- requirements
Module: tex_fetch

---
 rtl/tex_fetch_pkg.sv | 18 +
 rtl/tex_fetch_spi_flash_reader.sv | 116 +++++++++++
 rtl/tex_fetch.sv | 90 +++++++++
 tb/tb_tex_fetch.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tex_fetch_pkg.sv
// rtl/tex_fetch_pkg.sv - shared SPI texture fetch constants and FSM encoding
package tex_fetch_pkg;

    localparam int          READ_LEN_DEF = 64;
    localparam int          ADDR_LEN_DEF = 24;
    localparam logic [7:0]  SPI_CMD_DEF  = 8'h03;
    localparam int          CNT_W        = 7;
    localparam int          SLICE_W      = 9;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/tex_fetch_spi_flash_reader.sv
// rtl/tex_fetch_spi_flash_reader.sv - SPI READ sequencer: command, address, data shift
module spi_flash_reader
    import tex_fetch_pkg::*;
#(
    parameter int         READ_LEN = READ_LEN_DEF,
    parameter int         ADDR_LEN = ADDR_LEN_DEF,
    parameter logic [7:0] SPI_CMD  = SPI_CMD_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_start,
    input  logic                i_swap,
    input  logic [ADDR_LEN-1:0] i_addr,
    output logic                o_csb,
    output logic                o_mosi,
    input  logic                i_miso,
    output logic                o_busy,
    output logic                o_done,
    output logic [READ_LEN-1:0] o_fill
);

    fetch_state_e         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_LEN-1:0]  sh_q, sh_d;
    logic [READ_LEN-1:0]  fill_q, fill_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end
            end
            ST_CMD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(7)) begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                    sh_d    = i_addr;
                end
            end
            ST_ADDR: begin
                cnt_d = cnt_q + 1'b1;
                sh_d  = {sh_q[ADDR_LEN-2:0], 1'b0};
                if (cnt_q == CNT_W'(ADDR_LEN - 1)) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(READ_LEN - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end
            end
            ST_DONE: begin
                // A new start wins over swap; the owner commits the swap on the same edge.
                if (i_start) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end else if (i_swap) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
        o_csb  = ~o_busy;
        o_done = (state_q == ST_DONE);
        o_mosi = 1'b0;
        if (state_q == ST_CMD) begin
            o_mosi = SPI_CMD[3'd7 - cnt_q[2:0]];
        end else if (state_q == ST_ADDR) begin
            o_mosi = sh_q[ADDR_LEN-1];
        end
    end

    // MISO is sampled on the falling clk edge, i.e. the rising edge of sclk = ~clk.
    always_comb begin
        fill_d = fill_q;
        if (state_q == ST_DATA) begin
            fill_d = {fill_q[READ_LEN-2:0], i_miso};
        end
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign o_fill = fill_q;

endmodule

// File: rtl/tex_fetch.sv
// rtl/tex_fetch.sv - texture line fetch from SPI flash with double-buffered texel output
module tex_fetch
    import tex_fetch_pkg::*;
#(
    parameter int         READ_LEN = READ_LEN_DEF,
    parameter int         ADDR_LEN = ADDR_LEN_DEF,
    parameter logic [7:0] SPI_CMD  = SPI_CMD_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_start,
    input  logic [1:0] i_wall,
    input  logic       i_side,
    input  logic [5:0] i_texu,
    input  logic       i_swap,
    input  logic [5:0] i_texv,
    output logic       o_tex_csb,
    output logic       o_tex_sclk,
    output logic       o_tex_mosi,
    input  logic       i_tex_miso,
    output logic       o_texel,
    output logic       o_busy,
    output logic       o_underrun
);

    logic [SLICE_W-1:0]  slice_q, slice_d;
    logic [READ_LEN-1:0] display_q, display_d;
    logic                underrun_q, underrun_d;
    logic [READ_LEN-1:0] fill;
    logic [ADDR_LEN-1:0] spi_addr;
    logic [1:0]          wall_idx;
    logic                busy;
    logic                done;
    logic                accept;

    assign wall_idx = i_wall - 2'd1;
    assign accept   = i_start && !busy;
    assign spi_addr = ADDR_LEN'({slice_q, 3'b000});

    spi_flash_reader #(
        .READ_LEN (READ_LEN),
        .ADDR_LEN (ADDR_LEN),
        .SPI_CMD  (SPI_CMD)
    ) u_reader (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (i_start),
        .i_swap  (i_swap),
        .i_addr  (spi_addr),
        .o_csb   (o_tex_csb),
        .o_mosi  (o_tex_mosi),
        .i_miso  (i_tex_miso),
        .o_busy  (busy),
        .o_done  (done),
        .o_fill  (fill)
    );

    always_comb begin
        slice_d    = slice_q;
        display_d  = display_q;
        underrun_d = underrun_q;
        if (accept) begin
            slice_d = {wall_idx, i_side, i_texu};
        end
        if (i_swap && done) begin
            display_d  = fill;
            underrun_d = 1'b0;
        end else if (i_swap && busy) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slice_q    <= '0;
            display_q  <= '0;
            underrun_q <= 1'b0;
        end else begin
            slice_q    <= slice_d;
            display_q  <= display_d;
            underrun_q <= underrun_d;
        end
    end

    assign o_tex_sclk = ~clk;
    assign o_busy     = busy;
    assign o_underrun = underrun_q;
    assign o_texel    = display_q[i_texv];

endmodule

// File: tb/tb_tex_fetch.sv
// tb/tb_tex_fetch.sv - scoreboard bench for tex_fetch with a behavioural SPI flash
module tb_tex_fetch;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_start = 1'b0;
    logic [1:0] i_wall = 2'd1;
    logic       i_side = 1'b0;
    logic [5:0] i_texu = '0;
    logic       i_swap = 1'b0;
    logic [5:0] i_texv = '0;
    logic       i_tex_miso = 1'b0;
    logic       o_tex_csb, o_tex_sclk, o_tex_mosi, o_texel, o_busy, o_underrun;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] hdr_q[$];
    logic [63:0] disp_q[$];
    logic [63:0] flash_word = '0;
    logic [63:0] cur_disp = '0;

    tex_fetch dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_start    (i_start),
        .i_wall     (i_wall),
        .i_side     (i_side),
        .i_texu     (i_texu),
        .i_swap     (i_swap),
        .i_texv     (i_texv),
        .o_tex_csb  (o_tex_csb),
        .o_tex_sclk (o_tex_sclk),
        .o_tex_mosi (o_tex_mosi),
        .i_tex_miso (i_tex_miso),
        .o_texel    (o_texel),
        .o_busy     (o_busy),
        .o_underrun (o_underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_hdr(input logic [1:0] w, input logic s, input logic [5:0] u);
        logic [1:0]  widx;
        logic [8:0]  slice;
        logic [23:0] addr;
        widx  = w - 2'd1;
        slice = {widx, s, u};
        addr  = {12'h000, slice, 3'b000};
        return {8'h03, addr};
    endfunction

    task automatic read_display(output logic [63:0] v);
        v = '0;
        for (int i = 0; i < 64; i++) begin
            i_texv = 6'(i);
            #1;
            v[i] = o_texel;
        end
    endtask

    task automatic begin_fetch(input logic [1:0] w, input logic s, input logic [5:0] u,
                               input logic [63:0] data);
        i_wall = w; i_side = s; i_texu = u;
        flash_word = data;
        hdr_q.push_back(exp_hdr(w, s, u));
        disp_q.push_back(data);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic do_swap();
        i_swap = 1'b1;
        @(posedge clk); #1;
        i_swap = 1'b0;
    endtask

    // Entered 1 time unit after the edge that accepted i_start; plays the flash slave.
    task automatic run_fetch(input int swap_at, input int start_at, input int rst_at,
                             output int len, output logic [31:0] hdr, output logic data_mosi);
        int k;
        bit seen;
        k = 0; seen = 0; len = 0; hdr = '0; data_mosi = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            i_swap = 1'b0;
            i_start = 1'b0;
            if (o_tex_csb) begin
                if (seen) break;
            end else begin
                seen = 1;
                if (k < 32) begin
                    hdr = {hdr[30:0], o_tex_mosi};
                end else begin
                    data_mosi = data_mosi | o_tex_mosi;
                    if (k < 96) i_tex_miso = flash_word[95 - k];
                end
                if (k == swap_at) i_swap = 1'b1;
                if (k == start_at) begin
                    i_start = 1'b1; i_wall = 2'd3; i_side = 1'b0; i_texu = 6'h11;
                end
                if (k == rst_at) begin
                    reset_n = 1'b0;
                    #1;
                    chk("rst_csb", 64'(o_tex_csb), 64'd1);
                    chk("rst_texel", 64'(o_texel), 64'd0);
                    chk("rst_busy", 64'(o_busy), 64'd0);
                    chk("rst_mosi", 64'(o_tex_mosi), 64'd0);
                    len = k + 1;
                    i_tex_miso = 1'b0;
                    return;
                end
                k++;
                len = k;
            end
            @(posedge clk); #1;
        end
        i_tex_miso = 1'b0;
    endtask

    task automatic finish_fetch(input string tag, input int len, input logic [31:0] hdr,
                                input logic data_mosi);
        logic [31:0] eh;
        eh = hdr_q.pop_front();
        chk({tag, "_csb_len"}, 64'(len), 64'd96);
        chk({tag, "_hdr"}, 64'(hdr), 64'(eh));
        chk({tag, "_mosi_data"}, 64'(data_mosi), 64'd0);
        chk({tag, "_busy_done"}, 64'(o_busy), 64'd0);
    endtask

    initial begin
        int          len;
        logic [31:0] hdr;
        logic        dm;
        logic [63:0] v;
        logic [63:0] dropped;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_csb", 64'(o_tex_csb), 64'd1);
        chk("reset_mosi", 64'(o_tex_mosi), 64'd0);
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_underrun", 64'(o_underrun), 64'd0);
        chk("reset_texel", 64'(o_texel), 64'd0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_csb", 64'(o_tex_csb), 64'd1);

        // Fetch A: known line, then swap into display.
        begin_fetch(2'd2, 1'b1, 6'h2A, 64'hF000_0000_0000_0001);
        run_fetch(-1, -1, -1, len, hdr, dm);
        finish_fetch("A", len, hdr, dm);
        i_texv = 6'd63; #1;
        chk("A_pre_swap_texel", 64'(o_texel), 64'd0);
        do_swap();
        cur_disp = disp_q.pop_front();
        chk("A_underrun", 64'(o_underrun), 64'd0);
        i_texv = 6'd63; #1; chk("A_texel63", 64'(o_texel), 64'd1);
        i_texv = 6'd60; #1; chk("A_texel60", 64'(o_texel), 64'd1);
        i_texv = 6'd59; #1; chk("A_texel59", 64'(o_texel), 64'd0);
        i_texv = 6'd1;  #1; chk("A_texel1", 64'(o_texel), 64'd0);
        read_display(v);
        chk("A_display", v, cur_disp);

        // Fetch B: swap lands at data bit 40.
        @(posedge clk); #1;
        begin_fetch(2'd1, 1'b0, 6'h3F, 64'h1234_5678_9ABC_DEF0);
        run_fetch(32 + 40, -1, -1, len, hdr, dm);
        finish_fetch("B", len, hdr, dm);
        chk("B_underrun_set", 64'(o_underrun), 64'd1);
        read_display(v);
        chk("B_display_kept", v, cur_disp);
        do_swap();
        cur_disp = disp_q.pop_front();
        chk("B_underrun_clr", 64'(o_underrun), 64'd0);
        read_display(v);
        chk("B_display", v, cur_disp);

        // Fetch C: a second start during ADDR must not relatch.
        @(posedge clk); #1;
        begin_fetch(2'd3, 1'b1, 6'h05, 64'hA5A5_0F0F_3C3C_FFFF);
        run_fetch(-1, 15, -1, len, hdr, dm);
        finish_fetch("C", len, hdr, dm);

        // Start and swap in the same DONE cycle.
        i_texv = 6'd0;
        i_wall = 2'd2; i_side = 1'b0; i_texu = 6'h3C;
        flash_word = 64'h8000_0000_0000_0003;
        hdr_q.push_back(exp_hdr(2'd2, 1'b0, 6'h3C));
        i_start = 1'b1; i_swap = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_swap = 1'b0;
        cur_disp = disp_q.pop_front();
        disp_q.push_back(flash_word);
        chk("D_swap_texel0", 64'(o_texel), 64'(cur_disp[0]));
        chk("D_csb_low", 64'(o_tex_csb), 64'd0);
        chk("D_busy", 64'(o_busy), 64'd1);
        run_fetch(-1, -1, -1, len, hdr, dm);
        finish_fetch("D", len, hdr, dm);
        do_swap();
        cur_disp = disp_q.pop_front();
        read_display(v);
        chk("D_display", v, cur_disp);

        // Fetch E: reset asserted at data bit 10.
        i_texv = 6'd0;
        @(posedge clk); #1;
        begin_fetch(2'd1, 1'b1, 6'h00, 64'hFFFF_0000_FFFF_0000);
        run_fetch(-1, -1, 32 + 10, len, hdr, dm);
        dropped = 64'(hdr_q.pop_front());
        dropped = disp_q.pop_front();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("E_post_csb", 64'(o_tex_csb), 64'd1);
        chk("E_post_busy", 64'(o_busy), 64'd0);
        chk("E_post_underrun", 64'(o_underrun), 64'd0);
        do_swap();
        read_display(v);
        chk("E_idle_swap_display", v, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

endmodule
